// File: rtl/calc1_pkg.sv
// -----------------------------------------------------------------------------
// calc1_pkg
//   Shared types and constants for the calc1 port responder.
//   - command codes (CMD_*), response codes (RESP_*)
//   - field widths for command, data and response
//   - response record carried through the delay pipeline
//   - responder FSM state encoding
// -----------------------------------------------------------------------------
package calc1_pkg;

    localparam int CMD_W  = 4;
    localparam int DATA_W = 32;
    localparam int RESP_W = 2;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_LSH = 4'd5;
    localparam logic [CMD_W-1:0] CMD_RSH = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_OVF  = 2'd2;
    localparam logic [RESP_W-1:0] RESP_INV  = 2'd3;

    typedef struct packed {
        logic [RESP_W-1:0] resp;
        logic [DATA_W-1:0] data;
    } rsp_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OP2  = 1'b1
    } state_t;

endpackage

// File: rtl/calc1_alu.sv
// -----------------------------------------------------------------------------
// calc1_alu
//   Combinational calc1 arithmetic: {cmd, op1, op2} -> {resp, data}.
//   All arithmetic is unsigned 32-bit. data is forced to 0 unless resp is OK.
// Ports:
//   i_cmd   [3:0]  command code
//   i_op1   [31:0] operand 1
//   i_op2   [31:0] operand 2
//   o_resp  [1:0]  response code
//   o_data  [31:0] result (0 when o_resp != RESP_OK)
// -----------------------------------------------------------------------------
module calc1_alu
    import calc1_pkg::*;
(
    input  logic [CMD_W-1:0]  i_cmd,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    output logic [RESP_W-1:0] o_resp,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W:0] w_sum;
    logic [4:0]      w_shamt;

    assign w_sum   = {1'b0, i_op1} + {1'b0, i_op2};
    assign w_shamt = i_op2[4:0];

    always_comb begin
        o_resp = RESP_INV;
        o_data = '0;
        case (i_cmd)
            CMD_ADD: begin
                // Carry out of bit 31 is the only overflow condition.
                if (w_sum[DATA_W]) begin
                    o_resp = RESP_OVF;
                end else begin
                    o_resp = RESP_OK;
                    o_data = w_sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (i_op2 > i_op1) begin
                    o_resp = RESP_OVF;
                end else begin
                    o_resp = RESP_OK;
                    o_data = i_op1 - i_op2;
                end
            end
            CMD_LSH: begin
                o_resp = RESP_OK;
                o_data = i_op1 << w_shamt;
            end
            CMD_RSH: begin
                o_resp = RESP_OK;
                o_data = i_op1 >> w_shamt;
            end
            default: begin
                o_resp = RESP_INV;
                o_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc1_port_responder.sv
// -----------------------------------------------------------------------------
// calc1_port_responder
//   Responder end of one calc1 request port. Accepts a two-cycle
//   command/operand frame, computes the result and returns it RESP_LAT edges
//   after the operand-2 sampling edge, visible for exactly one cycle.
//
// Parameters:
//   RESP_LAT  edges from operand-2 sample to response visibility (1..8)
//
// Ports:
//   c_clk        in   clock, all logic on posedge
//   reset        in   synchronous active-high reset
//   req_cmd_in   in   [0:3]  command (bit 0 = MSB)
//   req_data_in  in   [0:31] operand 1 in command cycle, operand 2 next cycle
//   out_resp     out  [0:1]  0 none / 1 ok / 2 over-underflow / 3 invalid
//   out_data     out  [0:31] result, 0 unless out_resp = 1
//   busy         out  high while waiting for operand 2
//
// Build option:
//   CALC1_RESP_STRICT_EN  a nonzero command during the operand-2 cycle is a
//                         framing error: the current request completes with
//                         resp 3 and the offending command is discarded.
// -----------------------------------------------------------------------------
module calc1_port_responder
    import calc1_pkg::*;
#(
    parameter int RESP_LAT = 3
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [0:3]  req_cmd_in,
    input  logic [0:31] req_data_in,
    output logic [0:1]  out_resp,
    output logic [0:31] out_data,
    output logic        busy
);

    localparam int LAST = RESP_LAT - 1;

    // Big-endian port vectors re-expressed as conventional [N-1:0] values.
    logic [CMD_W-1:0]  w_cmd;
    logic [DATA_W-1:0] w_din;

    assign w_cmd = req_cmd_in;
    assign w_din = req_data_in;

    state_t            r_state;
    state_t            w_next;
    logic [CMD_W-1:0]  r_cmd;
    logic [DATA_W-1:0] r_op1;

    logic              w_latch;
    logic              w_push;
    logic              w_frame_err;
    rsp_t              w_alu_rsp;
    rsp_t              w_push_rsp;

    logic [LAST:0]     r_vld_pipe;
    rsp_t [LAST:0]     r_pipe;

    // Operand 2 goes straight from the port into the ALU; the OP2-cycle
    // edge captures the result directly into pipeline stage 0.
    calc1_alu u_alu (
        .i_cmd  (r_cmd),
        .i_op1  (r_op1),
        .i_op2  (w_din),
        .o_resp (w_alu_rsp.resp),
        .o_data (w_alu_rsp.data)
    );

`ifdef CALC1_RESP_STRICT_EN
    assign w_frame_err = (r_state == ST_OP2) && (w_cmd != CMD_NOP);
`else
    assign w_frame_err = 1'b0;
`endif

    always_comb begin
        w_push_rsp = w_alu_rsp;
        if (w_frame_err) begin
            w_push_rsp.resp = RESP_INV;
            w_push_rsp.data = '0;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_push  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd != CMD_NOP) begin
                    w_latch = 1'b1;
                    w_next  = ST_OP2;
                end
            end
            ST_OP2: begin
                // Any command seen here is never taken as a new request.
                w_push = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_NOP;
            r_op1   <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_cmd <= w_cmd;
                r_op1 <= w_din;
            end
        end
    end

    // Delay line: a valid bit per stage travels with the {resp, data} record.
    // Push into stage 0 and shift out of the last stage happen together.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_vld_pipe <= '0;
            r_pipe     <= '0;
        end else begin
            r_vld_pipe[0] <= w_push;
            r_pipe[0]     <= w_push ? w_push_rsp : '0;
            for (int i = 1; i <= LAST; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_pipe[i]     <= r_pipe[i-1];
            end
        end
    end

    assign out_resp = r_vld_pipe[LAST] ? r_pipe[LAST].resp : RESP_NONE;
    assign out_data = (r_vld_pipe[LAST] && (r_pipe[LAST].resp == RESP_OK))
                      ? r_pipe[LAST].data : '0;
    assign busy     = (r_state == ST_OP2);

endmodule
